note_oscillator: RTL and testbench
==================================

Name: note_oscillator

Overview:
- Consumer end of the sequencer note interface: takes the 4-bit note code the sequencer drives and turns it into an audible square wave with a simple gate/release amplitude envelope.
- Runs on the 10 kHz system clock and uses a 16-bit phase accumulator, so pitch resolution is sub-cycle.
- Sits between the sequencer/keypad note mux and the audio output stage. Its output is the 4-bit sample sent to the output stage.

Parameters:
- ACC_W, 16, phase accumulator width; wave_out = acc[ACC_W-1].
- RELEASE_STEP, 40, clock cycles per 1-LSB amplitude decrement during release.
- AMP_MAX, 15, amplitude on attack and during sustain; must fit 4 bits.

Ports:
- clk  input  1  10 kHz system clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  block enable, driven from sequencer_on or the global play mode; low forces silence.
- note  input  4  note code. 0 = no note; 1..8 = C4 D4 E4 F4 G4 A4 B4 C5; 9..15 = D5..C6.
- wave_out  output  1  square wave, acc MSB.
- amplitude  output  4  current envelope level.
- sample  output  4  wave_out ? amplitude : 0.
- active  output  1  high in SUSTAIN or RELEASE.

Behaviour:
- Reset: the following are cleared on the rising edge while rst=1, and rst has priority over everything:
  - state=IDLE, acc=0, inc_reg=0, amplitude=0, rel_cnt=0.
  - wave_out=0, sample=0, active=0.
- Increment lookup (combinational from note):
  - Notes 1..8 map to 1717, 1927, 2163, 2287, 2569, 2884, 3237, 3428.
  - Note n in 9..15 uses 2x the value of note n-7 (9 = 3854 … 15 = 6856).
  - Note 0 maps to 0.
- Accumulator:
  - acc <= acc + inc_reg every cycle in SUSTAIN or RELEASE, modulo 2^ACC_W (wraps silently).
  - acc holds at 0 in IDLE.
- Registered outputs: wave_out, amplitude and active are registers. sample is combinational from them.
- State machine (IDLE, SUSTAIN, RELEASE). Evaluated each edge, first match wins:
  1. rst -> IDLE, as described above.
  2. enable=0 -> IDLE; acc, amplitude and rel_cnt cleared that edge, from any state.
  3. IDLE, note!=0:
     - -> SUSTAIN, inc_reg <= lut(note), amplitude <= AMP_MAX.
     - acc stays 0 this edge; the first add happens on the next edge.
  4. SUSTAIN, note!=0 and note!=current note:
     - inc_reg <= lut(note), amplitude <= AMP_MAX.
     - acc is not reset, so the phase is continuous (glitch-free pitch change).
  5. SUSTAIN, note==0:
     - -> RELEASE, rel_cnt <= 0.
     - amplitude holds, inc_reg holds (the last pitch keeps sounding).
  6. RELEASE, note!=0:
     - Retrigger: -> SUSTAIN, inc_reg <= lut(note), amplitude <= AMP_MAX.
     - acc is not reset.
  7. RELEASE, note==0:
     - rel_cnt increments. When rel_cnt reaches RELEASE_STEP-1 it wraps to 0 and amplitude decrements by 1.
     - When the decrement takes amplitude to 0, go to IDLE on the same edge and clear acc.
- The current note is held in a 4-bit register updated whenever inc_reg loads.
- Latency:
  - A note presented before edge k produces state, amplitude and inc_reg changes at edge k.
  - The pitch takes effect in acc from edge k+1.
- Release length: exactly AMP_MAX*RELEASE_STEP = 600 cycles from the RELEASE entry edge to the IDLE edge.
- Boundaries:
  - A note of 0 in IDLE does nothing.
  - enable rising with note!=0 enters SUSTAIN on that edge.
  - amplitude never underflows.
  - No X may propagate from an out-of-table note; all 16 codes are defined.

Test Plan:
- Reset: hold rst=1 for 3 cycles with note=5, enable=1 -> all outputs 0 and active=0. Release rst with note=5 -> SUSTAIN at the next edge, amplitude=15.
- Pitch: enable=1, apply note=6 before edge 0 -> after edge 12 acc=34608 and wave_out=1; after edge 11 wave_out=0. Over 10000 cycles, count 440±1 wave_out rising edges.
- Phase continuity: note=1 for 50 cycles, then note=8 -> acc does not reset at the change edge, and the next increment is 3428.
- Release: in SUSTAIN, set note=0 at edge R -> amplitude=15 through edge R+39, 14 at R+40, 0 and IDLE at R+600 with acc=0, active=0.
- Retrigger: note=0 at edge R, then note=3 at edge R+100 (amplitude=13) -> SUSTAIN, amplitude=15, inc=2163, acc not cleared.
- Enable priority: during SUSTAIN, drop enable on the same edge note changes 2->7 -> IDLE, amplitude=0, acc=0, inc_reg ignored. Re-raise enable with note=7 -> SUSTAIN, inc=3237.

Source files
------------

// File: rtl/note_oscillator.sv
// Note-code to square-wave oscillator with a gate/release amplitude envelope.
// A 16-bit phase accumulator sets the pitch; its MSB is the square wave.
module note_oscillator #(
    parameter int ACC_W        = 16,
    parameter int RELEASE_STEP = 40,
    parameter int AMP_MAX      = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] note,
    output logic       wave_out,
    output logic [3:0] amplitude,
    output logic [3:0] sample,
    output logic       active
);

    localparam int REL_W = $clog2(RELEASE_STEP + 1);

    typedef enum logic [1:0] {
        IDLE,
        SUSTAIN,
        RELEASE
    } state_t;

    state_t state, state_n;

    logic [ACC_W-1:0] acc, acc_n;
    logic [ACC_W-1:0] inc_reg, inc_n;
    logic [ACC_W-1:0] lut_inc;
    logic [3:0]       amp_n;
    logic [3:0]       cur_note, note_n;
    logic [REL_W-1:0] rel_cnt, rel_n;

    // Upper octave entries are exactly twice the matching lower-octave entry.
    always_comb begin
        lut_inc = '0;
        case (note)
            4'd1:    lut_inc = ACC_W'(1717);
            4'd2:    lut_inc = ACC_W'(1927);
            4'd3:    lut_inc = ACC_W'(2163);
            4'd4:    lut_inc = ACC_W'(2287);
            4'd5:    lut_inc = ACC_W'(2569);
            4'd6:    lut_inc = ACC_W'(2884);
            4'd7:    lut_inc = ACC_W'(3237);
            4'd8:    lut_inc = ACC_W'(3428);
            4'd9:    lut_inc = ACC_W'(3854);
            4'd10:   lut_inc = ACC_W'(4326);
            4'd11:   lut_inc = ACC_W'(4574);
            4'd12:   lut_inc = ACC_W'(5138);
            4'd13:   lut_inc = ACC_W'(5768);
            4'd14:   lut_inc = ACC_W'(6474);
            4'd15:   lut_inc = ACC_W'(6856);
            default: lut_inc = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        inc_n   = inc_reg;
        amp_n   = amplitude;
        rel_n   = rel_cnt;
        note_n  = cur_note;
        if (!enable) begin
            state_n = IDLE;
            acc_n   = '0;
            amp_n   = '0;
            rel_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    acc_n = '0;
                    if (note != 4'd0) begin
                        state_n = SUSTAIN;
                        inc_n   = lut_inc;
                        note_n  = note;
                        amp_n   = 4'(AMP_MAX);
                    end
                end
                SUSTAIN: begin
                    // Phase keeps running across pitch changes.
                    acc_n = acc + inc_reg;
                    if (note == 4'd0) begin
                        state_n = RELEASE;
                        rel_n   = '0;
                    end else if (note != cur_note) begin
                        inc_n  = lut_inc;
                        note_n = note;
                        amp_n  = 4'(AMP_MAX);
                    end
                end
                RELEASE: begin
                    acc_n = acc + inc_reg;
                    if (note != 4'd0) begin
                        state_n = SUSTAIN;
                        inc_n   = lut_inc;
                        note_n  = note;
                        amp_n   = 4'(AMP_MAX);
                    end else if (rel_cnt == REL_W'(RELEASE_STEP - 1)) begin
                        rel_n = '0;
                        if (amplitude <= 4'd1) begin
                            amp_n   = '0;
                            state_n = IDLE;
                            acc_n   = '0;
                        end else begin
                            amp_n = amplitude - 4'd1;
                        end
                    end else begin
                        rel_n = rel_cnt + REL_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    acc_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            inc_reg   <= '0;
            amplitude <= '0;
            rel_cnt   <= '0;
            cur_note  <= '0;
            wave_out  <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            inc_reg   <= inc_n;
            amplitude <= amp_n;
            rel_cnt   <= rel_n;
            cur_note  <= note_n;
            wave_out  <= acc_n[ACC_W-1];
            active    <= (state_n != IDLE);
        end
    end

    assign sample = wave_out ? amplitude : 4'd0;

endmodule

// File: tb/tb_note_oscillator.sv
// Scoreboard bench for note_oscillator: the driver queues expected values per
// clock edge; a negedge monitor pops and compares them.
module tb_note_oscillator;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] note;
    logic       wave_out;
    logic [3:0] amplitude;
    logic [3:0] sample;
    logic       active;

    note_oscillator dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .note      (note),
        .wave_out  (wave_out),
        .amplitude (amplitude),
        .sample    (sample),
        .active    (active)
    );

    always #5 clk = ~clk;

    localparam int K_AMP = 0;
    localparam int K_WAV = 1;
    localparam int K_ACT = 2;
    localparam int K_ACC = 3;
    localparam int K_INC = 4;
    localparam int K_SMP = 5;

    typedef struct {
        int    cyc;
        string name;
        int    kind;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void exp_at(int c, string nm, int k, int v);
        exp_t e;
        e.cyc  = c;
        e.name = nm;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endfunction

    function automatic int actual(int k);
        case (k)
            K_AMP:   return int'(amplitude);
            K_WAV:   return int'(wave_out);
            K_ACT:   return int'(active);
            K_ACC:   return int'(dut.acc);
            K_INC:   return int'(dut.inc_reg);
            default: return int'(sample);
        endcase
    endfunction

    task automatic chk(string nm, int act, int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0d want %0d", nm, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: missed edge %0d (now %0d)", e.name, e.cyc, cyc);
            end else begin
                chk(e.name, actual(e.kind), e.val);
            end
        end
    end

    task automatic go_to(int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    int e0, x, c, r, s, r2, t, cnt;
    logic prev;

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        note   = 4'd5;

        exp_at(3, "rst_amp", K_AMP, 0);
        exp_at(3, "rst_act", K_ACT, 0);
        exp_at(3, "rst_wav", K_WAV, 0);
        exp_at(3, "rst_smp", K_SMP, 0);
        exp_at(3, "rst_acc", K_ACC, 0);
        go_to(3);
        rst = 1'b0;
        exp_at(4, "start_act", K_ACT, 1);
        exp_at(4, "start_amp", K_AMP, 15);
        exp_at(4, "start_inc", K_INC, 2569);
        go_to(4);

        // Pitch: A4 from a clean IDLE
        enable = 1'b0;
        go_to(5);
        enable = 1'b1;
        note   = 4'd6;
        e0     = 6;
        exp_at(e0, "a4_inc", K_INC, 2884);
        exp_at(e0, "a4_acc0", K_ACC, 0);
        exp_at(e0 + 11, "a4_wav11", K_WAV, 0);
        exp_at(e0 + 11, "a4_acc11", K_ACC, 31724);
        exp_at(e0 + 11, "a4_smp11", K_SMP, 0);
        exp_at(e0 + 12, "a4_wav12", K_WAV, 1);
        exp_at(e0 + 12, "a4_acc12", K_ACC, 34608);
        exp_at(e0 + 12, "a4_smp12", K_SMP, 15);
        go_to(e0 + 12);
        prev = wave_out;
        cnt  = 0;
        for (int i = 0; i < 10000; i++) begin
            go_to(cyc + 1);
            if (wave_out && !prev) cnt++;
            prev = wave_out;
        end
        n_cmp++;
        if (cnt < 439 || cnt > 441) begin
            n_bad++;
            $display("FAIL rise_440: got %0d want 440+-1", cnt);
        end

        // Phase continuity across a pitch change
        enable = 1'b0;
        x      = cyc + 1;
        go_to(x);
        enable = 1'b1;
        note   = 4'd1;
        c      = x + 51;
        exp_at(x + 1, "pc_inc1", K_INC, 1717);
        exp_at(c - 1, "pc_acc_pre", K_ACC, 18597);
        go_to(c - 1);
        note = 4'd8;
        exp_at(c, "pc_acc_chg", K_ACC, 20314);
        exp_at(c, "pc_inc8", K_INC, 3428);
        exp_at(c + 1, "pc_acc_next", K_ACC, 23742);
        go_to(c + 1);

        // Release envelope
        r    = c + 2;
        note = 4'd0;
        exp_at(r, "rel_act0", K_ACT, 1);
        exp_at(r, "rel_amp0", K_AMP, 15);
        exp_at(r + 39, "rel_amp39", K_AMP, 15);
        exp_at(r + 40, "rel_amp40", K_AMP, 14);
        exp_at(r + 599, "rel_amp599", K_AMP, 1);
        exp_at(r + 599, "rel_act599", K_ACT, 1);
        exp_at(r + 600, "rel_amp600", K_AMP, 0);
        exp_at(r + 600, "rel_act600", K_ACT, 0);
        exp_at(r + 600, "rel_acc600", K_ACC, 0);
        exp_at(r + 601, "idle_note0", K_ACT, 0);
        go_to(r + 601);

        // Retrigger during release
        s    = r + 602;
        note = 4'd5;
        go_to(s - 0);
        go_to(s + 1);
        r2   = s + 2;
        note = 4'd0;
        exp_at(r2 + 99, "rt_amp99", K_AMP, 13);
        exp_at(r2 + 99, "rt_act99", K_ACT, 1);
        go_to(r2 + 99);
        note = 4'd3;
        exp_at(r2 + 100, "rt_amp", K_AMP, 15);
        exp_at(r2 + 100, "rt_inc", K_INC, 2163);
        exp_at(r2 + 100, "rt_acc", K_ACC, 65430);
        exp_at(r2 + 101, "rt_acc_next", K_ACC, 2057);
        go_to(r2 + 101);

        // Enable priority over a simultaneous note change
        t    = r2 + 102;
        note = 4'd2;
        exp_at(t, "ep_inc2", K_INC, 1927);
        go_to(t);
        enable = 1'b0;
        note   = 4'd7;
        exp_at(t + 1, "ep_act", K_ACT, 0);
        exp_at(t + 1, "ep_amp", K_AMP, 0);
        exp_at(t + 1, "ep_acc", K_ACC, 0);
        exp_at(t + 1, "ep_inc_hold", K_INC, 1927);
        go_to(t + 1);
        enable = 1'b1;
        exp_at(t + 2, "ep_re_act", K_ACT, 1);
        exp_at(t + 2, "ep_re_inc", K_INC, 3237);
        exp_at(t + 2, "ep_re_amp", K_AMP, 15);
        exp_at(t + 3, "ep_re_acc", K_ACC, 3237);
        go_to(t + 3);

        // Upper octave table entries
        note = 4'd15;
        exp_at(t + 4, "lut15", K_INC, 6856);
        go_to(t + 4);
        note = 4'd9;
        exp_at(t + 5, "lut9", K_INC, 3854);
        go_to(t + 5);

        go_to(cyc + 3);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_drain: %0d entries left", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
